// File: rtl/mul_seq_param.sv
// Sequential radix-2 shift-add multiplier, W x W -> 2W, signed or unsigned.
// One operand bit is retired per clock; the sign is applied once at the end.
module mul_seq_param #(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] y,
    output logic           busy
);

    localparam int unsigned CntW = $clog2(W);
    localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q, state_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [2*W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic [2*W-1:0]   y_q, y_d;

    logic [W-1:0]     mag_a, mag_b;
    logic [2*W-1:0]   acc_sum;

    // Magnitudes fit in W unsigned bits, including the most-negative value.
    assign mag_a   = (is_signed && a[W-1]) ? (~a + 1'b1) : a;
    assign mag_b   = (is_signed && b[W-1]) ? (~b + 1'b1) : b;
    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        y_d      = y_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    mcand_d  = {{W{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    neg_d    = is_signed & (a[W-1] ^ b[W-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                // Shifting the multiplicand each step stands in for shifting by the count.
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    y_d     = neg_q ? -acc_sum : acc_sum;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            y_q      <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            y_q      <= y_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign y         = y_q;

endmodule

// File: tb/tb_mul_seq_param.sv
// Self-checking bench for mul_seq_param at W=8 and W=16 against an integer product model.
module tb_mul_seq_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        iv8 = 1'b0, s8 = 1'b0, or8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ir8, ov8, busy8;
    logic [15:0] y8;

    logic        iv16 = 1'b0, s16 = 1'b0, or16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ir16, ov16, busy16;
    logic [31:0] y16;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mul_seq_param #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .is_signed(s8), .out_valid(ov8), .out_ready(or8), .y(y8), .busy(busy8)
    );

    mul_seq_param #(.W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .is_signed(s16), .out_valid(ov16), .out_ready(or16), .y(y16), .busy(busy16)
    );

    // Exact product of two w-bit operands, reduced mod 2^(2w).
    function automatic logic [31:0] ref_mul(int w, logic [15:0] x, logic [15:0] z, bit s);
        longint xi, zi, p, mask;
        mask = (longint'(1) << w) - 1;
        xi = longint'(x) & mask;
        zi = longint'(z) & mask;
        if (s && x[w-1]) xi = xi - (longint'(1) << w);
        if (s && z[w-1]) zi = zi - (longint'(1) << w);
        p = xi * zi;
        return 32'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb, input bit ts,
                          input logic [15:0] want);
        int lat;
        logic [15:0] model;
        model = 16'(ref_mul(8, {8'h00, ta}, {8'h00, tb}, ts));
        n_vec++;
        if (model !== want) begin
            n_bad++;
            $display("FAIL op8_model got %h want %h", model, want);
        end
        n_vec++;
        if (ir8 !== 1'b1) begin
            n_bad++;
            $display("FAIL op8_in_ready got %b want 1", ir8);
        end
        a8 = ta; b8 = tb; s8 = ts; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        s8 = ~ts;
        a8 = 8'($urandom);
        lat = 0;
        while (ov8 !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        n_vec++;
        if (lat != 8) begin
            n_bad++;
            $display("FAIL op8_latency got %0d want 8", lat);
        end
        n_vec++;
        if (y8 !== want) begin
            n_bad++;
            $display("FAIL op8_y a=%h b=%h s=%b got %h want %h", ta, tb, ts, y8, want);
        end
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        n_vec++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0) begin
            n_bad++;
            $display("FAIL op8_return_idle got ir=%b ov=%b busy=%b want 1 0 0", ir8, ov8, busy8);
        end
    endtask

    task automatic do_op16(input logic [15:0] ta, input logic [15:0] tb, input bit ts);
        int lat;
        logic [31:0] want;
        want = ref_mul(16, ta, tb, ts);
        a16 = ta; b16 = tb; s16 = ts; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        s16 = ~ts;
        lat = 0;
        while (ov16 !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        n_vec++;
        if (lat != 16) begin
            n_bad++;
            $display("FAIL op16_latency got %0d want 16", lat);
        end
        n_vec++;
        if (y16 !== want) begin
            n_bad++;
            $display("FAIL op16_y a=%h b=%h s=%b got %h want %h", ta, tb, ts, y16, want);
        end
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
        n_vec++;
        if (ir16 !== 1'b1 || ov16 !== 1'b0) begin
            n_bad++;
            $display("FAIL op16_return_idle got ir=%b ov=%b want 1 0", ir16, ov16);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        n_vec++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0 || y8 !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset8 got ir=%b ov=%b busy=%b y=%h want 1 0 0 0000",
                     ir8, ov8, busy8, y8);
        end
        n_vec++;
        if (ir16 !== 1'b1 || ov16 !== 1'b0 || y16 !== 32'h0) begin
            n_bad++;
            $display("FAIL reset16 got ir=%b ov=%b y=%h want 1 0 0", ir16, ov16, y16);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        do_op8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
        do_op8(8'h80, 8'h80, 1'b1, 16'h4000);
        do_op8(8'hFF, 8'h7F, 1'b1, 16'hFF81);
        do_op8(8'hFB, 8'h03, 1'b1, 16'hFFF1);
        do_op8(8'h07, 8'h80, 1'b1, 16'hFC80);
        do_op8(8'hFF, 8'h7F, 1'b0, 16'h7E81);
        do_op8(8'h00, 8'hA5, 1'b0, 16'h0000);
    endtask

    task automatic test_backpressure;
        int lat;
        a8 = 8'hFB; b8 = 8'h03; s8 = 1'b1; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        lat = 0;
        while (ov8 !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (ov8 !== 1'b1 || y8 !== 16'hFFF1 || ir8 !== 1'b0 || busy8 !== 1'b1) begin
                n_bad++;
                $display("FAIL stall_%0d got ov=%b y=%h ir=%b busy=%b want 1 fff1 0 1",
                         i, ov8, y8, ir8, busy8);
            end
            iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
            @(posedge clk); #1;
            iv8 = 1'b0;
        end
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        n_vec++;
        if (ov8 !== 1'b0 || ir8 !== 1'b1 || y8 !== 16'hFFF1) begin
            n_bad++;
            $display("FAIL stall_release got ov=%b ir=%b y=%h want 0 1 fff1", ov8, ir8, y8);
        end
        @(posedge clk); #1;
        n_vec++;
        if (ov8 !== 1'b0 || ir8 !== 1'b1 || busy8 !== 1'b0 || y8 !== 16'hFFF1) begin
            n_bad++;
            $display("FAIL stall_hold got ov=%b ir=%b busy=%b y=%h want 0 1 0 fff1",
                     ov8, ir8, busy8, y8);
        end
    endtask

    task automatic test_reset_mid;
        a8 = 8'd9; b8 = 8'd11; s8 = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (ov8 !== 1'b0 || y8 !== 16'h0000 || ir8 !== 1'b1 || busy8 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid got ov=%b y=%h ir=%b busy=%b want 0 0000 1 0",
                     ov8, y8, ir8, busy8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op8(8'd3, 8'd4, 1'b0, 16'd12);
    endtask

    task automatic test_sweep16;
        logic [15:0] pick[4];
        logic [15:0] ta, tb;
        pick[0] = 16'h8000; pick[1] = 16'hFFFF; pick[2] = 16'h0000; pick[3] = 16'h7FFF;
        do_op16(16'h8000, 16'h8000, 1'b1);
        do_op16(16'hFFFF, 16'hFFFF, 1'b0);
        do_op16(16'h8000, 16'hFFFF, 1'b1);
        do_op16(16'hFFFF, 16'h8000, 1'b0);
        for (int i = 0; i < 16; i++) begin
            ta = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom);
            tb = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom);
            do_op16(ta, tb, 1'($urandom));
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] q[$];
        logic [15:0] exp_y;
        int last_acc = -1;
        int cyc = 0;
        int got = 0;
        bit acc_now;
        or8 = 1'b1;
        a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
        iv8 = 1'b1;
        while (got < 6 && cyc < 300) begin
            acc_now = (ir8 === 1'b1);
            if (acc_now) q.push_back(16'(ref_mul(8, {8'h00, a8}, {8'h00, b8}, s8)));
            @(posedge clk); #1;
            cyc++;
            if (acc_now) begin
                if (last_acc >= 0) begin
                    n_vec++;
                    if (cyc - last_acc != 10) begin
                        n_bad++;
                        $display("FAIL b2b_spacing got %0d want 10", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
            end
            if (ov8 === 1'b1) begin
                exp_y = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
                n_vec++;
                if (y8 !== exp_y) begin
                    n_bad++;
                    $display("FAIL b2b_y_%0d got %h want %h", got, y8, exp_y);
                end
                got++;
            end
        end
        iv8 = 1'b0;
        n_vec++;
        if (got != 6) begin
            n_bad++;
            $display("FAIL b2b_timeout got %0d results want 6", got);
        end
        @(posedge clk); #1;
        or8 = 1'b0;
        n_vec++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_drain got ir=%b ov=%b want 1 0", ir8, ov8);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_backpressure;
        test_reset_mid;
        test_sweep16;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
